game_round_ctrl: RTL and testbench

- Round sequencer for the binary number game; drives the 4-bit random number generator through its enable input.
- Each round: arms the generator, captures a target, shows it, waits for the player's switch guess or a timeout, then judges and updates score/lives.
- Sits between the generator, the debounced player inputs and the display/LED drivers.

---
 rtl/game_round_ctrl_pkg.sv | 6 +
 rtl/game_round_ctrl_cycle_timer.sv | 22 ++
 rtl/game_round_ctrl.sv | 129 ++++++++++++
 tb/tb_game_round_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/game_round_ctrl_pkg.sv
// game_pkg: shared state encoding and widths for the round sequencer
package game_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int LIVES_W = 3;
  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, WAIT_GUESS, JUDGE, SHOW, GAME_OVER} state_t;
endpackage

// File: rtl/game_round_ctrl_cycle_timer.sv
// cycle_timer: clearable up-counter that parks on its terminal count
module cycle_timer #(
  parameter int LIMIT = 16,
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] count_q, count_d;
  // clear wins over count; stop at the terminal value so it never wraps
  always_comb begin
    tc = count_q == W'(LIMIT - 1);
    count_d = clr ? '0 : (en && !tc) ? count_q + 1'b1 : count_q;
  end
  // counter state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: per-round sequencer for the binary number game
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SCORE_W = 8,
  parameter int LIVES_INIT = 3,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int SHOW_CYC = 25_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               guess_submit,
  input  logic [WIDTH-1:0]   guess,
  output logic               gen_enable,
  input  logic [WIDTH-1:0]   gen_result,
  output logic [WIDTH-1:0]   target,
  output logic               target_valid,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);
  localparam int RETRY_W = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d, prev_q, prev_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic verdict_q, verdict_d, hit_q, hit_d, miss_q, miss_d;
  logic gen_enable_q, gen_enable_d, target_valid_q, target_valid_d, game_over_q, game_over_d;
  logic guess_tc, show_tc;
  cycle_timer #(.LIMIT(TIMEOUT_CYC)) u_guess_tmr (
    .clk(clk), .rst_n(rst_n), .clr(state_q == CAPTURE), .en(state_q == WAIT_GUESS), .tc(guess_tc)
  );
  cycle_timer #(.LIMIT(SHOW_CYC)) u_show_tmr (
    .clk(clk), .rst_n(rst_n), .clr(state_q == JUDGE), .en(state_q == SHOW), .tc(show_tc)
  );
  // round sequencing; the registered strobes are decoded from the next state
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    prev_d = prev_q;
    retry_d = retry_q;
    score_d = score_q;
    lives_d = lives_q;
    verdict_d = verdict_q;
    hit_d = hit_q;
    miss_d = miss_q;
    case (state_q)
      IDLE, GAME_OVER: if (start) begin
        state_d = ARM;
        score_d = '0;
        lives_d = LIVES_W'(LIVES_INIT);
        retry_d = '0;
      end
      ARM: state_d = CAPTURE;
      CAPTURE: if (gen_result == prev_q && retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        state_d = ARM;
      end else begin
        target_d = gen_result;
        prev_d = gen_result;
        retry_d = '0;
        state_d = WAIT_GUESS;
      end
      WAIT_GUESS: begin
        verdict_d = guess_submit ? guess == target_q : 1'b0;
        state_d = (guess_submit || guess_tc) ? JUDGE : state_q;
      end
      JUDGE: begin
        score_d = verdict_q ? (&score_q ? score_q : score_q + 1'b1) : score_q;
        lives_d = (verdict_q || lives_q == '0) ? lives_q : lives_q - 1'b1;
        hit_d = verdict_q;
        miss_d = !verdict_q;
        state_d = SHOW;
      end
      SHOW: if (show_tc) begin
        hit_d = 1'b0;
        miss_d = 1'b0;
        state_d = lives_q == '0 ? GAME_OVER : ARM;
      end
      default: state_d = IDLE;
    endcase
    gen_enable_d = state_d == ARM;
    target_valid_d = state_d == WAIT_GUESS;
    game_over_d = state_d == GAME_OVER;
  end
  // state and registered outputs; reset aborts any round at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      target_q <= '0;
      prev_q <= '0;
      retry_q <= '0;
      score_q <= '0;
      lives_q <= '0;
      verdict_q <= 1'b0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      gen_enable_q <= 1'b0;
      target_valid_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      prev_q <= prev_d;
      retry_q <= retry_d;
      score_q <= score_d;
      lives_q <= lives_d;
      verdict_q <= verdict_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      gen_enable_q <= gen_enable_d;
      target_valid_q <= target_valid_d;
      game_over_q <= game_over_d;
    end
  assign gen_enable = gen_enable_q;
  assign target = target_q;
  assign target_valid = target_valid_q;
  assign hit = hit_q;
  assign miss = miss_q;
  assign score = score_q;
  assign lives = lives_q;
  assign game_over = game_over_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed scenarios with a verdict scoreboard
module tb_game_round_ctrl;
  localparam int TO = 20;
  localparam int SH = 10;
  typedef struct packed {logic hit; logic miss; logic [7:0] score; logic [2:0] lives;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, guess_submit = 1'b0;
  logic [3:0] guess = '0, gen_result = '0, target, exp_target = '0;
  logic gen_enable, target_valid, hit, miss, game_over;
  logic [7:0] score, exp_score = '0;
  logic [2:0] lives, exp_lives = '0;
  logic [3:0] gen_q[$];
  exp_t sb[$];
  int tests = 0, fails = 0;
  game_round_ctrl #(.SCORE_W(8), .LIVES_INIT(3), .TIMEOUT_CYC(TO), .SHOW_CYC(SH), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess_submit(guess_submit), .guess(guess),
    .gen_enable(gen_enable), .gen_result(gen_result), .target(target), .target_valid(target_valid),
    .hit(hit), .miss(miss), .score(score), .lives(lives), .game_over(game_over)
  );
  always #5 clk = ~clk;
  // generator model: registered result that advances on an enabled edge
  always @(posedge clk)
    if (gen_enable) begin
      if (gen_q.size() != 0) gen_result <= gen_q.pop_front();
      else gen_result <= 4'd0;
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {gen_enable, target, target_valid, hit, miss, score, lives, game_over}, 0);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_score = '0;
    exp_lives = 3'd3;
  endtask
  task automatic wait_target(input logic [3:0] v, input int exp_arms);
    int arms = 0, n = 0;
    while (!target_valid && n < 100) begin
      if (gen_enable) arms++;
      tick(1);
      n++;
    end
    chk("target_valid_seen", target_valid, 1);
    chk("target_value", target, v);
    chk("arm_count", arms, exp_arms);
    exp_target = v;
  endtask
  // mode 0: submit at once, 1: let it time out, 2: submit on the final timer cycle
  task automatic play(input logic [3:0] g, input int mode);
    exp_t e;
    int n = 0;
    e.hit = (mode != 1) && (g == exp_target);
    e.miss = !e.hit;
    if (e.hit) exp_score = (exp_score == 8'hff) ? exp_score : exp_score + 8'd1;
    else exp_lives = (exp_lives == 0) ? exp_lives : exp_lives - 3'd1;
    e.score = exp_score;
    e.lives = exp_lives;
    sb.push_back(e);
    if (mode == 1) begin
      while (target_valid && n < 100) begin
        tick(1);
        n++;
      end
      chk("timeout_len", n, TO);
    end else begin
      if (mode == 2) tick(TO - 1);
      guess = g;
      guess_submit = 1'b1;
      tick(1);
      guess_submit = 1'b0;
    end
    chk("judge_tv_low", target_valid, 0);
    chk("judge_no_verdict", {hit, miss}, 0);
    tick(1);
    e = sb.pop_front();
    chk("hit", hit, e.hit);
    chk("miss", miss, e.miss);
    chk("score", score, e.score);
    chk("lives", lives, e.lives);
    n = 0;
    while ((hit || miss) && n < 100) begin
      tick(1);
      n++;
    end
    chk("show_len", n, SH);
    if (exp_lives == 0) chk("enter_game_over", game_over, 1);
    else chk("next_arm", gen_enable, 1);
  endtask
  initial begin
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(1);
    chk_zero("idle");
    gen_q.push_back(4'd5);
    pulse_start();
    chk("start_arm", gen_enable, 1);
    chk("start_lives", lives, 3);
    tick(1);
    chk("arm_one_cycle", gen_enable, 0);
    tick(1);
    chk("tv_two_after_arm", target_valid, 1);
    wait_target(4'd5, 0);
    play(4'd5, 0);
    gen_q.push_back(4'd9);
    wait_target(4'd9, 1);
    play(4'd6, 0);
    gen_q.push_back(4'd3);
    wait_target(4'd3, 1);
    play(4'd0, 1);
    gen_q.push_back(4'd4);
    wait_target(4'd4, 1);
    play(4'd1, 0);
    tick(5);
    chk("go_hold", game_over, 1);
    guess = 4'd4;
    guess_submit = 1'b1;
    tick(1);
    guess_submit = 1'b0;
    tick(3);
    chk("go_submit_ignored", {hit, miss, gen_enable, target_valid}, 0);
    chk("go_score_hold", score, 1);
    chk("go_lives_hold", lives, 0);
    gen_q.push_back(4'd7);
    pulse_start();
    chk("restart_go_clear", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    chk("restart_arm", gen_enable, 1);
    wait_target(4'd7, 1);
    play(4'd7, 2);
    repeat (4) gen_q.push_back(4'd7);
    wait_target(4'd7, 4);
    play(4'd7, 0);
    gen_q.push_back(4'd7);
    gen_q.push_back(4'd2);
    wait_target(4'd2, 2);
    play(4'd2, 0);
    for (int i = 0; i < 253; i++) begin
      logic [3:0] v;
      v = i[0] ? 4'd1 : 4'd3;
      gen_q.push_back(v);
      wait_target(v, 1);
      play(v, 0);
    end
    chk("score_saturated", score, 255);
    gen_q.push_back(4'd6);
    wait_target(4'd6, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_wait");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    gen_q.delete();
    gen_q.push_back(4'd5);
    pulse_start();
    chk("arm_before_reset", gen_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_arm", gen_enable, 0);
    chk_zero("async_reset_arm");
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
